// File: rtl/arbitro_rodada.sv
// Round referee for the two-player reaction duel: random arming delay, go, winner pulse, match end.
// Define FOUL_DETECT_EN to judge presses made before go as false starts.
module arbitro_rodada #(
    parameter int DELAY_MIN  = 50_000_000,
    parameter int DLY_BITS   = 26,
    parameter int TIMEOUT    = 250_000_000,
    parameter int HOLD       = 25_000_000,
    parameter int WIN_TARGET = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic btn1,
    input  logic btn2,
    output logic go,
    output logic p1vic,
    output logic p2vic,
    output logic match_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_ARMED,
        S_GO,
        S_RESULT,
        S_END
    } state_t;

    localparam logic [3:0]  TARGET   = 4'(WIN_TARGET);
    localparam logic [31:0] DMIN     = 32'(DELAY_MIN);
    localparam logic [31:0] TOUT     = 32'(TIMEOUT);
    localparam logic [31:0] HOLD_CY  = 32'(HOLD);
    // DLY_BITS may exceed the 16-bit lfsr; the missing upper bits read as zero.
    localparam logic [31:0] DLY_MASK = 32'((64'd1 << DLY_BITS) - 64'd1);

    state_t      state;
    logic [15:0] lfsr;
    logic [31:0] lfsr_ext;
    logic        btn1_q, btn2_q;
    logic        press1, press2;
    logic        dec_p1, dec_p2, dec_void;
    logic [31:0] count;
    logic [3:0]  wins1, wins2;

    assign lfsr_ext = {16'd0, lfsr};
    assign press1   = btn1 & ~btn1_q;
    assign press2   = btn2 & ~btn2_q;

    // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr   <= 16'hACE1;
            btn1_q <= 1'b0;
            btn2_q <= 1'b0;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            btn1_q <= btn1;
            btn2_q <= btn2;
        end
    end

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        dec_p1   = 1'b0;
        dec_p2   = 1'b0;
        dec_void = 1'b0;
        if (state == S_GO) begin
            dec_p1   = press1 & ~press2;
            dec_p2   = press2 & ~press1;
            dec_void = press1 & press2;
        end
`ifdef FOUL_DETECT_EN
        else if (state == S_ARMED) begin
            dec_p1   = press2 & ~press1;
            dec_p2   = press1 & ~press2;
            dec_void = press1 & press2;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            count      <= '0;
            wins1      <= '0;
            wins2      <= '0;
            go         <= 1'b0;
            p1vic      <= 1'b0;
            p2vic      <= 1'b0;
            match_over <= 1'b0;
        end else begin
            p1vic <= 1'b0;
            p2vic <= 1'b0;
            if (dec_p1 || dec_p2) begin
                state <= S_RESULT;
                go    <= 1'b0;
                count <= HOLD_CY;
                p1vic <= dec_p1;
                p2vic <= dec_p2;
                if (dec_p1 && wins1 != TARGET) wins1 <= wins1 + 4'd1;
                if (dec_p2 && wins2 != TARGET) wins2 <= wins2 + 4'd1;
            end else if (dec_void) begin
                state <= S_RELEASE;
                go    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) state <= S_RELEASE;
                    end
                    S_RELEASE: begin
                        if (!btn1 && !btn2) begin
                            count <= DMIN + (lfsr_ext & DLY_MASK);
                            state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (count <= 32'd1) begin
                            state <= S_GO;
                            go    <= 1'b1;
                            count <= TOUT;
                        end else begin
                            count <= count - 32'd1;
                        end
                    end
                    S_GO: begin
                        if (count <= 32'd1) begin
                            state <= S_IDLE;
                            go    <= 1'b0;
                        end else begin
                            count <= count - 32'd1;
                        end
                    end
                    S_RESULT: begin
                        if (count <= 32'd1) begin
                            if (wins1 == TARGET || wins2 == TARGET) begin
                                state      <= S_END;
                                match_over <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            count <= count - 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rodada.sv
// Self-checking bench for arbitro_rodada: directed round scenarios, then random play,
// all compared every cycle against a procedural model of the round rules.
module tb_arbitro_rodada;

    localparam int P_DELAY_MIN = 4;
    localparam int P_DLY_BITS  = 2;
    localparam int P_TIMEOUT   = 10;
    localparam int P_HOLD      = 3;
    localparam int P_TARGET    = 2;

    localparam int O_NONE    = 0;
    localparam int O_P1      = 1;
    localparam int O_P2      = 2;
    localparam int O_VOID    = 3;
    localparam int O_TIMEOUT = 4;

    logic clock, reset, start, btn1, btn2;
    logic go, p1vic, p2vic, match_over;

    int checks = 0;
    int errors = 0;

    arbitro_rodada #(
        .DELAY_MIN (P_DELAY_MIN),
        .DLY_BITS  (P_DLY_BITS),
        .TIMEOUT   (P_TIMEOUT),
        .HOLD      (P_HOLD),
        .WIN_TARGET(P_TARGET)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .btn1      (btn1),
        .btn2      (btn2),
        .go        (go),
        .p1vic     (p1vic),
        .p2vic     (p2vic),
        .match_over(match_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          exp_go, exp_p1, exp_p2, exp_mo;
    int          m_w1, m_w2;
    logic [15:0] m_lfsr, s_lfsr;
    bit          m_prev1, m_prev2, pr1, pr2, s_b1, s_b2, s_start;

    task automatic model_clear();
        exp_go = 0; exp_p1 = 0; exp_p2 = 0; exp_mo = 0;
        m_w1 = 0; m_w2 = 0;
        m_lfsr = 16'hACE1;
        m_prev1 = 0; m_prev2 = 0;
    endtask

    // One clock edge as seen by the referee; ab=1 when reset cut in instead.
    task automatic tick(output bit ab);
        @(posedge clock or negedge reset);
        if (!reset) begin
            ab = 1;
            return;
        end
        ab      = 0;
        s_lfsr  = m_lfsr;
        m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        s_b1    = btn1;
        s_b2    = btn2;
        s_start = start;
        pr1     = s_b1 && !m_prev1;
        pr2     = s_b2 && !m_prev2;
        m_prev1 = s_b1;
        m_prev2 = s_b2;
    endtask

    task automatic run_match();
        bit ab;
        int dly, outcome;
        bit round_done;
        forever begin
            do begin tick(ab); if (ab) return; end while (!s_start);
            round_done = 0;
            while (!round_done) begin
                do begin tick(ab); if (ab) return; end while (s_b1 || s_b2);
                dly = P_DELAY_MIN + (int'(s_lfsr) % (1 << P_DLY_BITS));
                outcome = O_NONE;
                for (int i = 0; i < (dly > 1 ? dly : 1); i++) begin
                    tick(ab); if (ab) return;
`ifdef FOUL_DETECT_EN
                    if (pr1 || pr2) begin
                        outcome = (pr1 && pr2) ? O_VOID : (pr1 ? O_P2 : O_P1);
                        break;
                    end
`endif
                end
                if (outcome == O_NONE) begin
                    exp_go  = 1;
                    outcome = O_TIMEOUT;
                    for (int i = 0; i < P_TIMEOUT; i++) begin
                        tick(ab); if (ab) return;
                        if (pr1 || pr2) begin
                            outcome = (pr1 && pr2) ? O_VOID : (pr1 ? O_P1 : O_P2);
                            break;
                        end
                    end
                    exp_go = 0;
                end
                if (outcome == O_P1 || outcome == O_P2) begin
                    exp_p1 = (outcome == O_P1);
                    exp_p2 = (outcome == O_P2);
                    if (outcome == O_P1 && m_w1 < P_TARGET) m_w1++;
                    if (outcome == O_P2 && m_w2 < P_TARGET) m_w2++;
                    for (int h = 0; h < (P_HOLD > 1 ? P_HOLD : 1); h++) begin
                        tick(ab); if (ab) return;
                        exp_p1 = 0;
                        exp_p2 = 0;
                    end
                    if (m_w1 == P_TARGET || m_w2 == P_TARGET) begin
                        exp_mo = 1;
                        forever begin tick(ab); if (ab) return; end
                    end
                    round_done = 1;
                end else if (outcome == O_TIMEOUT) begin
                    round_done = 1;
                end
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            wait (reset === 1'b0);
            model_clear();
            wait (reset === 1'b1);
            run_match();
        end
    end

    always @(negedge clock) begin
        check("outputs{go,p1vic,p2vic,match_over}",
              {28'd0, go, p1vic, p2vic, match_over},
              {28'd0, exp_go, exp_p1, exp_p2, exp_mo});
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_go(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            cyc();
            ok = (go === 1'b1);
        end
    endtask

    task automatic observe(input int n, output int ng, output int n1, output int n2);
        ng = 0; n1 = 0; n2 = 0;
        repeat (n) begin
            cyc();
            ng += int'(go);
            n1 += int'(p1vic);
            n2 += int'(p2vic);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        int ng, n1, n2;
        start = 0; btn1 = 0; btn2 = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) cyc();
        check("reset_outputs", {go, p1vic, p2vic, match_over}, 4'b0000);
        reset = 1'b1;
        cyc();
        check("model_lfsr_step1", m_lfsr, 16'h59C3);
        cyc();
        check("model_lfsr_step2", m_lfsr, 16'hB387);

        // reset in the middle of GO
        pulse_start();
        wait_go(30, ok);
        check("t1_go_reached", ok, 1);
        cyc();
        reset = 1'b0;
        #1 check("t1_reset_clears", {go, p1vic, p2vic, match_over}, 4'b0000);
        cyc();
        reset = 1'b1;
        cyc();

        // player 1 presses two cycles into GO
        pulse_start();
        wait_go(30, ok);
        check("t2_go_reached", ok, 1);
        cyc(); cyc();
        btn1 = 1'b1;
        observe(8, ng, n1, n2);
        check("t2_p1_pulses", n1, 1);
        check("t2_p2_pulses", n2, 0);
        check("t2_go_after_press", ng, 0);
        check("model_wins_p1", m_w1, 1);
        btn1 = 1'b0;
        cyc();

        // simultaneous press voids the round and re-arms
        pulse_start();
        wait_go(30, ok);
        check("t3_go_reached", ok, 1);
        btn1 = 1'b1; btn2 = 1'b1;
        cyc();
        check("t3_void_no_pulse", {go, p1vic, p2vic}, 3'b000);
        btn1 = 1'b0; btn2 = 1'b0;
        wait_go(30, ok);
        check("t3_rearmed", ok, 1);
        observe(12, ng, n1, n2);
        check("t3_no_pulses", n1 + n2, 0);

        // no presses: go lasts exactly TIMEOUT cycles
        pulse_start();
        wait_go(30, ok);
        check("t4_go_reached", ok, 1);
        observe(14, ng, n1, n2);
        check("t4_go_cycles", ng + 1, P_TIMEOUT);
        check("t4_no_pulses", n1 + n2, 0);

        // player 2 presses while ARMED
        pulse_start();
        cyc();
        btn2 = 1'b1;
        observe(22, ng, n1, n2);
`ifdef FOUL_DETECT_EN
        check("t5_foul_p1_pulse", n1, 1);
        check("t5_foul_no_go", ng, 0);
`else
        check("t5_no_pulse", n1 + n2, 0);
        check("t5_go_cycles", ng, P_TIMEOUT);
`endif
        btn2 = 1'b0;
        repeat (4) cyc();

        // player 2 wins the match
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        for (int r = 0; r < P_TARGET; r++) begin
            pulse_start();
            wait_go(30, ok);
            check("t6_go_reached", ok, 1);
            btn2 = 1'b1;
            cyc();
            check("t6_p2_pulse", {p1vic, p2vic}, 2'b01);
            btn2 = 1'b0;
            observe(6, ng, n1, n2);
            check("t6_single_pulse", n1 + n2, 0);
        end
        check("t6_match_over", match_over, 1);
        pulse_start();
        btn1 = 1'b1; btn2 = 1'b1;
        observe(20, ng, n1, n2);
        check("t6_end_quiet", ng + n1 + n2, 0);
        check("t6_match_over_sticky", match_over, 1);
        btn1 = 1'b0; btn2 = 1'b0;

        // random play
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) btn1 = ~btn1;
            if ($urandom_range(0, 5) == 0) btn2 = ~btn2;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                cyc();
                reset = 1'b1;
            end
        end
        start = 0; btn1 = 0; btn2 = 0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
